// File: rtl/hsv_pkg.sv
// Shared HSV/RGB definitions: sector constants, no-hue threshold, packed word
// field positions and the converter FSM state type.
package hsv_pkg;

  localparam logic [2:0]  SectorCount    = 3'd6;
  localparam int unsigned HueSteps       = 32;
  localparam logic [7:0]  NoHueThreshold = 8'd192;

  // HSV word: {h, 8'h00, s, v}
  localparam int unsigned HsvHLsb   = 24;
  localparam int unsigned HsvPadLsb = 16;
  localparam int unsigned HsvSLsb   = 8;
  localparam int unsigned HsvVLsb   = 0;

  // RGB word: {b, 8'h00, g, r}
  localparam int unsigned RgbBLsb = 24;
  localparam int unsigned RgbGLsb = 8;
  localparam int unsigned RgbRLsb = 0;

  typedef enum logic [1:0] {
    S_ADDR  = 2'd0,
    S_CAPT  = 2'd1,
    S_CALC  = 2'd2,
    S_WRITE = 2'd3
  } conv_state_e;

  function automatic logic [31:0] pack_rgb(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
    logic [31:0] w;
    w = '0;
    w[RgbRLsb +: 8] = r;
    w[RgbGLsb +: 8] = g;
    w[RgbBLsb +: 8] = b;
    return w;
  endfunction

endpackage

// File: rtl/hsv_sector_decode.sv
// Combinational HSV -> RGB decode: p/q/t arithmetic and sector mux.
// Config macro HSV_NOHUE_GREY_EN: when defined, h >= 192 yields grey (r=g=b=v);
// otherwise such hues are wrapped by subtracting 192 and decoded normally.
module hsv_sector_decode
  import hsv_pkg::*;
(
  input  logic [7:0] i_h,
  input  logic [7:0] i_s,
  input  logic [7:0] i_v,
  output logic [7:0] o_r,
  output logic [7:0] o_g,
  output logic [7:0] o_b
);

  localparam int unsigned FracBits = $clog2(HueSteps);

  logic [7:0]  w_h_wrap;
  logic [2:0]  w_sector;
  logic [4:0]  w_f;
  logic [16:0] w_s_f;
  logic [16:0] w_s_nf;
  logic [16:0] w_p_prod;
  logic [16:0] w_q_prod;
  logic [16:0] w_t_prod;
  logic [7:0]  w_p;
  logic [7:0]  w_q;
  logic [7:0]  w_t;
  logic        w_unused_bits;

  assign w_h_wrap = (i_h >= NoHueThreshold) ? i_h - NoHueThreshold : i_h;
  assign w_sector = w_h_wrap[7:5];
  assign w_f      = w_h_wrap[4:0];

  // All products fit in 17 bits; each result is <= v so bits [15:8] carry it.
  assign w_s_f    = (17'(i_s) * 17'(w_f)) >> FracBits;
  assign w_s_nf   = (17'(i_s) * (17'(HueSteps) - 17'(w_f))) >> FracBits;
  assign w_p_prod = 17'(i_v) * (17'd256 - 17'(i_s));
  assign w_q_prod = 17'(i_v) * (17'd256 - w_s_f);
  assign w_t_prod = 17'(i_v) * (17'd256 - w_s_nf);

  assign w_p = w_p_prod[15:8];
  assign w_q = w_q_prod[15:8];
  assign w_t = w_t_prod[15:8];

  assign w_unused_bits = ^{w_p_prod[16], w_p_prod[7:0], w_q_prod[16], w_q_prod[7:0],
                           w_t_prod[16], w_t_prod[7:0]};

  // Sector mux; sectors outside 0..5 cannot occur after wrapping but fall back to grey.
  always_comb begin
    o_r = i_v;
    o_g = i_v;
    o_b = i_v;
    if (w_sector < SectorCount) begin
      case (w_sector)
        3'd0:    begin o_r = i_v; o_g = w_t; o_b = w_p; end
        3'd1:    begin o_r = w_q; o_g = i_v; o_b = w_p; end
        3'd2:    begin o_r = w_p; o_g = i_v; o_b = w_t; end
        3'd3:    begin o_r = w_p; o_g = w_q; o_b = i_v; end
        3'd4:    begin o_r = w_t; o_g = w_p; o_b = i_v; end
        default: begin o_r = i_v; o_g = w_p; o_b = w_q; end
      endcase
    end
`ifdef HSV_NOHUE_GREY_EN
    if (i_h >= NoHueThreshold) begin
      o_r = i_v;
      o_g = i_v;
      o_b = i_v;
    end
`endif
  end

endmodule

// File: rtl/convert_hsv_to_rgb.sv
// HSV -> RGB frame converter: reads packed HSV words from the frame SRAM, writes
// packed RGB words to the output region, 4 cycles per pixel.
// Config macro HSV_NOHUE_GREY_EN selects no-hue handling inside hsv_sector_decode.
module convert_hsv_to_rgb
  import hsv_pkg::*;
#(
  parameter int unsigned ImageWidth       = 320,
  parameter int unsigned ImageHeight      = 240,
  parameter int unsigned HSVStorageOffset = (ImageWidth * ImageHeight) * 2 + 2,
  parameter int unsigned RGBOutputOffset  = (ImageWidth * ImageHeight) * 3 + 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pause,
  input  logic        enable,
  input  logic [31:0] data_read,
  output logic        wren,
  output logic [31:0] data_write,
  output logic [17:0] address,
  output logic        done
);

  localparam int unsigned NumPixels = ImageWidth * ImageHeight;
  localparam int unsigned CntW      = $clog2(NumPixels + 1);

  conv_state_e r_state, w_state_d;
  logic [CntW-1:0] r_counter, w_counter_d, w_counter_inc;
  logic        r_wren, w_wren_d;
  logic [31:0] r_data_write, w_data_write_d;
  logic [17:0] r_address, w_address_d;
  logic        r_done, w_done_d;
  logic [7:0]  r_h, r_s, r_v, w_h_d, w_s_d, w_v_d;
  logic [31:0] r_rgb, w_rgb_d;
  logic [7:0]  w_r, w_g, w_b;
  logic        w_unused_pad;

  assign w_unused_pad  = ^data_read[HsvPadLsb +: 8];
  assign w_counter_inc = r_counter + 1'b1;

  hsv_sector_decode u_decode (
    .i_h (r_h),
    .i_s (r_s),
    .i_v (r_v),
    .o_r (w_r),
    .o_g (w_g),
    .o_b (w_b)
  );

  // Next-state: enable low clears, pause freezes, done idles, otherwise step the FSM.
  always_comb begin
    w_state_d      = r_state;
    w_counter_d    = r_counter;
    w_wren_d       = r_wren;
    w_data_write_d = r_data_write;
    w_address_d    = r_address;
    w_done_d       = r_done;
    w_h_d          = r_h;
    w_s_d          = r_s;
    w_v_d          = r_v;
    w_rgb_d        = r_rgb;
    if (!enable) begin
      w_state_d      = S_ADDR;
      w_counter_d    = '0;
      w_wren_d       = 1'b0;
      w_data_write_d = '0;
      w_address_d    = '0;
      w_done_d       = 1'b0;
    end else if (pause) begin
      // hold everything
    end else if (r_done) begin
      w_wren_d = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: begin
          w_wren_d    = 1'b0;
          w_address_d = 18'(32'(r_counter) + HSVStorageOffset);
          w_state_d   = S_CAPT;
        end
        S_CAPT: begin
          w_h_d     = data_read[HsvHLsb +: 8];
          w_s_d     = data_read[HsvSLsb +: 8];
          w_v_d     = data_read[HsvVLsb +: 8];
          w_state_d = S_CALC;
        end
        S_CALC: begin
          w_rgb_d   = pack_rgb(w_r, w_g, w_b);
          w_state_d = S_WRITE;
        end
        S_WRITE: begin
          w_address_d    = 18'(32'(r_counter) + RGBOutputOffset);
          w_data_write_d = r_rgb;
          w_wren_d       = 1'b1;
          w_counter_d    = w_counter_inc;
          if (32'(w_counter_inc) >= NumPixels) begin
            w_done_d = 1'b1;
          end
          w_state_d = S_ADDR;
        end
        default: w_state_d = S_ADDR;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_ADDR;
      r_counter    <= '0;
      r_wren       <= 1'b0;
      r_data_write <= '0;
      r_address    <= '0;
      r_done       <= 1'b0;
      r_h          <= '0;
      r_s          <= '0;
      r_v          <= '0;
      r_rgb        <= '0;
    end else begin
      r_state      <= w_state_d;
      r_counter    <= w_counter_d;
      r_wren       <= w_wren_d;
      r_data_write <= w_data_write_d;
      r_address    <= w_address_d;
      r_done       <= w_done_d;
      r_h          <= w_h_d;
      r_s          <= w_s_d;
      r_v          <= w_v_d;
      r_rgb        <= w_rgb_d;
    end
  end

  assign wren       = r_wren;
  assign data_write = r_data_write;
  assign address    = r_address;
  assign done       = r_done;

endmodule

// File: tb/tb_convert_hsv_to_rgb.sv
// Scoreboard bench for convert_hsv_to_rgb on a 4x2 frame: stimulus pushes expected
// writes, a monitor pops and compares on every new wren.
module tb_convert_hsv_to_rgb;

  localparam int W = 4;
  localparam int H = 2;
  localparam int NPIX = W * H;
  localparam int HSV_OFF = NPIX * 2 + 2;
  localparam int RGB_OFF = NPIX * 3 + 3;

  typedef struct packed {
    logic [17:0] addr;
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, pause, enable;
  logic [31:0] data_read;
  logic        wren;
  logic [31:0] data_write;
  logic [17:0] address;
  logic        done;

  logic [31:0] mem [0:63];
  exp_t        exp_q[$];
  int          wr_cnt [0:63];
  int          snap [0:63];
  int          n_vec = 0;
  int          n_bad = 0;
  logic        pause_q = 1'b0;

  always #5 clk = ~clk;

  assign data_read = (address < 18'd64) ? mem[address[5:0]] : 32'h0;

  always @(posedge clk) pause_q <= pause;

  convert_hsv_to_rgb #(
    .ImageWidth  (W),
    .ImageHeight (H)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pause      (pause),
    .enable     (enable),
    .data_read  (data_read),
    .wren       (wren),
    .data_write (data_write),
    .address    (address),
    .done       (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: spec formulas in plain integer arithmetic, sector table lookup.
  function automatic logic [31:0] ref_px(input int h, input int s, input int v);
    int hh, sec, f;
    int ch [4];
    int tbl [6][3];
    tbl = '{'{0, 3, 1}, '{2, 0, 1}, '{1, 0, 3}, '{1, 2, 0}, '{3, 1, 0}, '{0, 1, 2}};
`ifdef HSV_NOHUE_GREY_EN
    if (h >= 192) return {8'(v), 8'h00, 8'(v), 8'(v)};
`endif
    hh = (h >= 192) ? h - 192 : h;
    sec = hh / 32;
    f = hh % 32;
    ch[0] = v;
    ch[1] = (v * (256 - s)) / 256;
    ch[2] = (v * (256 - (s * f) / 32)) / 256;
    ch[3] = (v * (256 - (s * (32 - f)) / 32)) / 256;
    return {8'(ch[tbl[sec][2]]), 8'h00, 8'(ch[tbl[sec][1]]), 8'(ch[tbl[sec][0]])};
  endfunction

  // Fill the HSV region and queue the expected writes (first n_exp pixels).
  task automatic load_frame(input bit directed, input int n_exp, input bit ends_done);
    int hs [8];
    int ss [8];
    int vs [8];
    logic [31:0] ex [8];
    for (int n = 0; n < NPIX; n++) begin
      hs[n] = $urandom_range(255);
      ss[n] = $urandom_range(255);
      vs[n] = $urandom_range(255);
      ex[n] = ref_px(hs[n], ss[n], vs[n]);
    end
    if (directed) begin
      hs[0] = 0;   ss[0] = 255; vs[0] = 255; ex[0] = 32'h000000FF;
      hs[1] = 64;  ss[1] = 255; vs[1] = 255; ex[1] = 32'h0000FF00;
      hs[2] = 128; ss[2] = 255; vs[2] = 255; ex[2] = 32'hFF000000;
      hs[3] = 16;  ss[3] = 255; vs[3] = 255; ex[3] = 32'h000080FF;
      hs[4] = 37;  ss[4] = 0;   vs[4] = 100; ex[4] = 32'h64006464;
      hs[5] = 192; ss[5] = 200; vs[5] = 80;
`ifdef HSV_NOHUE_GREY_EN
      ex[5] = 32'h50005050;
`else
      ex[5] = ref_px(0, 200, 80);
`endif
    end
    for (int n = 0; n < NPIX; n++) begin
      mem[HSV_OFF + n] = {8'(hs[n]), 8'h00, 8'(ss[n]), 8'(vs[n])};
      if (n < n_exp) exp_q.push_back('{addr: 18'(RGB_OFF + n), data: ex[n],
                                        last: ends_done && (n == n_exp - 1)});
    end
    for (int a = 0; a < 64; a++) snap[a] = wr_cnt[a];
  endtask

  // Monitor: a wren held across a paused edge is a repeat, otherwise a new write.
  initial begin : monitor
    logic        prev_wren;
    logic [17:0] prev_addr;
    logic [31:0] prev_data;
    exp_t        e;
    prev_wren = 1'b0;
    prev_addr = '0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (wren) begin
        if (prev_wren && pause_q) begin
          check("repeat_addr", 32'(address), 32'(prev_addr));
          check("repeat_data", data_write, prev_data);
        end else if (exp_q.size() == 0) begin
          check("unexpected_write_addr", 32'(address), 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(address), 32'(e.addr));
          check("wr_data", data_write, e.data);
          check("wr_done", 32'(done), 32'(e.last));
          if (address < 18'd64) wr_cnt[address[5:0]]++;
        end
      end
      prev_wren = wren;
      prev_addr = address;
      prev_data = data_write;
    end
  end

  initial begin : main
    int cycles;
    for (int a = 0; a < 64; a++) begin
      mem[a] = 32'h0;
      wr_cnt[a] = 0;
      snap[a] = 0;
    end
    reset = 1'b1;
    enable = 1'b0;
    pause = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wren", 32'(wren), 32'd0);
    check("rst_addr", 32'(address), 32'd0);
    check("rst_data", data_write, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Frame A: directed pixels, no pause, timing checks.
    load_frame(1'b1, NPIX, 1'b1);
    enable = 1'b1;
    cycles = 0;
    while (!done && cycles < 1000) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    check("frame_cycles", 32'(cycles), 32'(NPIX * 4));
    @(negedge clk);
    check("wren_after_done", 32'(wren), 32'd0);
    repeat (4) @(negedge clk);
    check("done_held", 32'(done), 32'd1);
    check("idle_wren", 32'(wren), 32'd0);
    check("queue_a_empty", 32'(exp_q.size()), 32'd0);
    enable = 1'b0;
    @(negedge clk);
    check("dis_done", 32'(done), 32'd0);
    check("dis_addr", 32'(address), 32'd0);
    check("dis_data", data_write, 32'd0);

    // Frame B: random pixels with random pause; re-enable restarts at pixel 0.
    load_frame(1'b0, NPIX, 1'b1);
    enable = 1'b1;
    cycles = 0;
    while (!done && cycles < 2000) begin
      pause = ($urandom_range(3) == 0);
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    pause = 1'b0;
    check("frame_b_done", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    for (int n = 0; n < NPIX; n++)
      check("b_once", 32'(wr_cnt[RGB_OFF + n] - snap[RGB_OFF + n]), 32'd1);
    check("queue_b_empty", 32'(exp_q.size()), 32'd0);
    enable = 1'b0;
    @(negedge clk);

    // Frame C: pause 3 cycles in pixel 2's S_WRITE, then reset during pixel 6.
    load_frame(1'b0, 6, 1'b0);
    enable = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    pause = 1'b1;
    repeat (3) @(negedge clk);
    pause = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_wren", 32'(wren), 32'd0);
    check("abort_addr", 32'(address), 32'd0);
    check("abort_data", data_write, 32'd0);
    check("abort_done", 32'(done), 32'd0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    for (int n = 0; n < NPIX; n++)
      check("c_count", 32'(wr_cnt[RGB_OFF + n] - snap[RGB_OFF + n]), (n < 6) ? 32'd1 : 32'd0);
    check("queue_c_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/convert_hsv_to_rgb.md
# convert_hsv_to_rgb

Reads the packed HSV image written by the RGB→HSV stage, converts each pixel back to 8-bit RGB and writes it to a separate RGB output region of the shared frame SRAM. It uses the same single-port, enable/done, pause-able memory-master interface as the other image-processing stages. It exists so post-HSV filtering can be viewed and re-fed as RGB.

## Interface
Parameters:
- ImageWidth, 320: pixels per line.
- ImageHeight, 240: lines per frame.
- HSVStorageOffset, (ImageWidth*ImageHeight)*2+2: word address of HSV pixel 0.
- RGBOutputOffset, (ImageWidth*ImageHeight)*3+3: word address of RGB output pixel 0.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; highest priority.
- pause  in  1  1 = hold the FSM and all outputs.
- enable  in  1  1 = run; 0 = clear done and the counter.
- data_read  in  32  SRAM read data, valid the cycle after address is driven.
- wren  out  1  SRAM write strobe.
- data_write  out  32  SRAM write data.
- address  out  18  SRAM word address.
- done  out  1  frame complete; held until enable falls.

## Operation
- Input word format: {h[7:0], 8'h00, s[7:0], v[7:0]}. Valid h is 0..191 (32 steps per sector). h ≥ 192 means "no hue".
- Output word format: {b[7:0], 8'h00, g[7:0], r[7:0]}.
- Decode:
  - sector = h[7:5] (0..5).
  - f = h[4:0].
  - p = (v*(256-s))>>8.
  - q = (v*(256-((s*f)>>5)))>>8.
  - t = (v*(256-((s*(32-f))>>5)))>>8.
  - All products are computed at 17 bits. Results are truncated to 8 bits and never exceed v.
- Sector → (r,g,b): 0:(v,t,p), 1:(q,v,p), 2:(p,v,t), 3:(p,q,v), 4:(t,p,v), 5:(v,p,q).
- FSM, 2-bit state:
  - S_ADDR: wren←0, address←counter+HSVStorageOffset → S_CAPT.
  - S_CAPT: latch h, s, v from data_read → S_CALC.
  - S_CALC: register p, q, t and the sector → S_WRITE.
  - S_WRITE: address←counter+RGBOutputOffset, data_write←packed RGB, wren←1, counter←counter+1. If the new counter ≥ ImageWidth*ImageHeight, done←1. → S_ADDR.
- Unused state encodings go to S_ADDR.
- While done=1 and enable=1: FSM idle, wren←0, address and data_write hold.
- enable=0: done←0, counter←0, wren←0, address←0, data_write←0, state←S_ADDR.

## Timing
- Reset values: wren=0, data_write=0, address=0, done=0, counter=0, state=S_ADDR.
- Reset mid-frame aborts on the next edge; no partial write completes after reset is sampled.
- Throughput is 4 cycles per pixel, so 307200 cycles per 320×240 frame with pause=0.
- The write is registered at the end of S_WRITE. wren is high for exactly one cycle per pixel, absent pause.
- pause=1 in any state freezes state, counter and every output, including a wren already high.
  - The write repeats harmlessly with identical address and data.
  - The pixel sequence is unaffected.
- done rises in the same cycle as the final wren. wren falls on the following cycle.
- enable low during a frame takes effect on the next edge, same as reset, except that reset also forces state.
- Simultaneous reset and enable=1: reset wins.

## Configuration
Macro: HSV_NOHUE_GREY_EN.
- Defined: h ≥ 192 forces r=g=b=v, ignoring s.
- Undefined: h ≥ 192 is wrapped by subtracting 192, so sector = (h-192)[7:5], then decoded normally. Upstream writes s=0 for no-hue pixels, so the result is still grey for valid input.

## Structure
- Shared package `hsv_pkg` holds:
  - the sector-count constant 6;
  - the hue-steps-per-sector constant 32;
  - the no-hue threshold 192;
  - the HSV and RGB word field positions.
- The converter stage uses those field positions, so the two stages cannot drift.
- One sub-module, `hsv_sector_decode`: combinational h, s, v → r, g, b (p/q/t arithmetic and sector mux).
- The top holds the FSM, the counter and the memory interface.

## Test plan
- h=0, s=255, v=255 → 32'h000000FF written at RGBOutputOffset+n.
- h=64, s=255, v=255 → 32'h0000FF00. h=128, s=255, v=255 → 32'hFF000000.
- h=16, s=255, v=255 → g=128, word 32'h000080FF. h=37, s=0, v=100 → 32'h64006464.
- h=192, s=200, v=80:
  - with HSV_NOHUE_GREY_EN → 32'h50005050;
  - without it → same as h=0, s=200, v=80.
- 4×2 image, pause pulsed 3 cycles during S_WRITE, then reset asserted mid-pixel 6:
  - exactly pixels 0..5 written once per address;
  - after reset, all outputs are 0.
- Full 4×2 frame: done rises with the 8th wren; wren=0 next cycle; enable→0 clears done; re-enable restarts at pixel 0.
